// File: rtl/galvo_responder.sv
// galvo_responder
//   Steps a galvo mirror pair through a 2-D scan. Each trigger from the
//   frame sequencer moves the scan one point. The block loads new DAC codes,
//   waits the requested settle time and then pulses an acknowledge.
//
//   Build option: define GALVO_SNAKE_SCAN_EN for a serpentine scan. If it is
//   left undefined, the block scans raster order, where every row starts at
//   iX_START.
//
//   Ports
//     iCLK, iRST               clock; asynchronous active-high reset
//     iGALVO_CHANGE_TRIGGER    move request (asynchronous, long pulse)
//     iSCAN_RESET              synchronous return to scan start
//     iX_START/iX_STEP         column origin / signed step
//     iY_START/iY_STEP         row origin / signed step
//     iX_COUNT/iY_COUNT        columns per row / rows per frame (0 acts as 1)
//     iSETTLE_MILLISEC         settle time before acknowledge
//     oDAC_X/oDAC_Y            galvo DAC codes
//     oDAC_LOAD                one-cycle DAC latch strobe
//     oGALVO_ACK               one-cycle acknowledge
//     oX_INDEX/oY_INDEX        current column / row index
//     oBUSY                    block is not idle
//     oOVERRUN                 sticky: a trigger arrived while busy
module galvo_responder #(
  parameter int CLK_CYCLES_PER_MS = 50000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iGALVO_CHANGE_TRIGGER,
  input  logic        iSCAN_RESET,
  input  logic [15:0] iX_START,
  input  logic [15:0] iX_STEP,
  input  logic [15:0] iY_START,
  input  logic [15:0] iY_STEP,
  input  logic [15:0] iX_COUNT,
  input  logic [15:0] iY_COUNT,
  input  logic [7:0]  iSETTLE_MILLISEC,
  output logic [15:0] oDAC_X,
  output logic [15:0] oDAC_Y,
  output logic        oDAC_LOAD,
  output logic        oGALVO_ACK,
  output logic [15:0] oX_INDEX,
  output logic [15:0] oY_INDEX,
  output logic        oBUSY,
  output logic        oOVERRUN
);

  typedef enum logic [2:0] {ST_IDLE, ST_UPDATE, ST_LOAD, ST_SETTLE, ST_ACK} state_t;

  state_t      r_state, w_next;
  logic        r_sync1, r_sync2, r_sync_d;
  logic        r_first;
  logic [7:0]  r_settle_ms;
  logic [31:0] r_settle_cnt;
  logic [31:0] w_settle_cyc;
  logic        w_edge;
  logic [15:0] w_xcnt, w_ycnt;
  logic        w_x_more, w_y_more;
  logic [15:0] w_nx_x, w_nx_y, w_nx_xi, w_nx_yi;
`ifdef GALVO_SNAKE_SCAN_EN
  logic        r_dir;     // 1 = stepping backward along the row
  logic        w_nx_dir;
`endif

  // Rising edge of the synchronised trigger; a held trigger yields one edge.
  assign w_edge = r_sync2 & ~r_sync_d;

  assign w_settle_cyc = 32'(r_settle_ms) * 32'(CLK_CYCLES_PER_MS);

  // Counts are sampled live during ST_UPDATE, where they are consumed.
  assign w_xcnt   = (iX_COUNT == 16'd0) ? 16'd1 : iX_COUNT;
  assign w_ycnt   = (iY_COUNT == 16'd0) ? 16'd1 : iY_COUNT;
  // Widen to 17 bits so an index of 16'hFFFF cannot wrap in the compare.
  assign w_x_more = ({1'b0, oX_INDEX} + 17'd1) < {1'b0, w_xcnt};
  assign w_y_more = ({1'b0, oY_INDEX} + 17'd1) < {1'b0, w_ycnt};

  assign oDAC_LOAD  = (r_state == ST_LOAD);
  assign oGALVO_ACK = (r_state == ST_ACK);
  assign oBUSY      = (r_state != ST_IDLE);

  // Next scan position. The DAC registers double as the position registers.
  always_comb begin
    w_nx_x  = oDAC_X;
    w_nx_y  = oDAC_Y;
    w_nx_xi = oX_INDEX;
    w_nx_yi = oY_INDEX;
`ifdef GALVO_SNAKE_SCAN_EN
    w_nx_dir = r_dir;
`endif
    if (r_first) begin
      w_nx_x  = iX_START;
      w_nx_y  = iY_START;
      w_nx_xi = 16'd0;
      w_nx_yi = 16'd0;
`ifdef GALVO_SNAKE_SCAN_EN
      w_nx_dir = 1'b0;
`endif
    end else begin
`ifdef GALVO_SNAKE_SCAN_EN
      if (!r_dir && w_x_more) begin
        w_nx_xi = oX_INDEX + 16'd1;
        w_nx_x  = oDAC_X + iX_STEP;
      end else if (r_dir && oX_INDEX != 16'd0) begin
        w_nx_xi = oX_INDEX - 16'd1;
        w_nx_x  = oDAC_X - iX_STEP;
      end else if (w_y_more) begin
        // Row end: X holds, the row advances and the direction flips.
        w_nx_yi  = oY_INDEX + 16'd1;
        w_nx_y   = oDAC_Y + iY_STEP;
        w_nx_dir = ~r_dir;
      end else begin
        w_nx_xi  = 16'd0;
        w_nx_x   = iX_START;
        w_nx_yi  = 16'd0;
        w_nx_y   = iY_START;
        w_nx_dir = 1'b0;
      end
`else
      if (w_x_more) begin
        w_nx_xi = oX_INDEX + 16'd1;
        w_nx_x  = oDAC_X + iX_STEP;
      end else begin
        w_nx_xi = 16'd0;
        w_nx_x  = iX_START;
        if (w_y_more) begin
          w_nx_yi = oY_INDEX + 16'd1;
          w_nx_y  = oDAC_Y + iY_STEP;
        end else begin
          w_nx_yi = 16'd0;
          w_nx_y  = iY_START;
        end
      end
`endif
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_edge) w_next = ST_UPDATE;
      ST_UPDATE: w_next = ST_LOAD;
      ST_LOAD:   w_next = (r_settle_ms != 8'd0) ? ST_SETTLE : ST_ACK;
      ST_SETTLE: if (r_settle_cnt == 32'd0) w_next = ST_ACK;
      ST_ACK:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    // A scan reset wins over everything, including a coincident trigger edge.
    if (iSCAN_RESET) w_next = ST_IDLE;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync_d     <= 1'b0;
      r_first      <= 1'b1;
      r_settle_ms  <= 8'd0;
      r_settle_cnt <= 32'd0;
      oDAC_X       <= 16'd0;
      oDAC_Y       <= 16'd0;
      oX_INDEX     <= 16'd0;
      oY_INDEX     <= 16'd0;
      oOVERRUN     <= 1'b0;
`ifdef GALVO_SNAKE_SCAN_EN
      r_dir        <= 1'b0;
`endif
    end else begin
      r_sync1  <= iGALVO_CHANGE_TRIGGER;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
      if (iSCAN_RESET) begin
        // DAC codes are deliberately left alone so the mirror does not jump.
        r_first  <= 1'b1;
        oX_INDEX <= 16'd0;
        oY_INDEX <= 16'd0;
        oOVERRUN <= 1'b0;
`ifdef GALVO_SNAKE_SCAN_EN
        r_dir    <= 1'b0;
`endif
      end else begin
        if (w_edge && r_state != ST_IDLE) oOVERRUN <= 1'b1;
        if (r_state == ST_UPDATE) begin
          r_settle_ms <= iSETTLE_MILLISEC;
          r_first     <= 1'b0;
          oDAC_X      <= w_nx_x;
          oDAC_Y      <= w_nx_y;
          oX_INDEX    <= w_nx_xi;
          oY_INDEX    <= w_nx_yi;
`ifdef GALVO_SNAKE_SCAN_EN
          r_dir       <= w_nx_dir;
`endif
        end
        // Loaded with N-1 so that ST_SETTLE lasts exactly N cycles.
        if (r_state == ST_LOAD) begin
          if (w_settle_cyc != 32'd0) r_settle_cnt <= w_settle_cyc - 32'd1;
        end else if (r_state == ST_SETTLE && r_settle_cnt != 32'd0) begin
          r_settle_cnt <= r_settle_cnt - 32'd1;
        end
      end
    end
  end

endmodule

// File: doc/galvo_responder.md
GALVO_RESPONDER -- requirements
Module: galvo_responder

Interface
REQ-001 SHALL have parameter CLK_CYCLES_PER_MS, default 50000, the iCLK cycles per millisecond of settle time.
REQ-002 SHALL have ports (name, direction, width, meaning), clock and reset first:
- iCLK  in  1  sole clock.
- iRST  in  1  reset.
- iGALVO_CHANGE_TRIGGER  in  1  move request; millisecond-long high pulse from the frame sequencer.
- iSCAN_RESET  in  1  synchronous return to scan start.
- iX_START, iX_STEP  in  16 each  column origin and signed two's-complement step.
- iY_START, iY_STEP  in  16 each  row origin and signed two's-complement step.
- iX_COUNT, iY_COUNT  in  16 each  columns per row, rows per frame.
- iSETTLE_MILLISEC  in  8  settle time before acknowledge.
- oDAC_X, oDAC_Y  out  16 each  galvo DAC codes.
- oDAC_LOAD  out  1  one-cycle DAC latch strobe.
- oGALVO_ACK  out  1  one-cycle acknowledge pulse to the sequencer.
- oX_INDEX, oY_INDEX  out  16 each  current column and row index.
- oBUSY  out  1  high when state is not ST_IDLE.
- oOVERRUN  out  1  sticky flag, set when a trigger is dropped.
REQ-003 SHALL use one clock, iCLK; iRST SHALL be asynchronous and active-high.

Function
REQ-004 SHALL pass iGALVO_CHANGE_TRIGGER through a 2-flop synchronizer and a third delay flop; a trigger edge is sync2 high and delay-flop low.
REQ-005 FSM states SHALL be ST_IDLE, ST_UPDATE, ST_LOAD, ST_SETTLE and ST_ACK.
REQ-006 SHALL make these transitions:
- ST_IDLE to ST_UPDATE on a trigger edge.
- ST_UPDATE to ST_LOAD.
- ST_LOAD to ST_SETTLE if the latched settle count is nonzero, else to ST_ACK.
- ST_SETTLE to ST_ACK when its cycle counter expires.
- ST_ACK to ST_IDLE.
REQ-007 In ST_UPDATE the block SHALL latch iSETTLE_MILLISEC, iX_COUNT and iY_COUNT, and update the position registers; a latched count of 0 SHALL be treated as 1.
REQ-008 The first trigger after reset or iSCAN_RESET SHALL set X to iX_START, Y to iY_START and both indices to 0, without advancing.
REQ-009 Each later trigger SHALL advance the scan:
- If x_idx+1 is below the X count: x_idx increments and X += iX_STEP.
- Otherwise: x_idx goes to 0, X to iX_START, and the row advances (y_idx increments, Y += iY_STEP).
- When y_idx+1 equals the Y count: y_idx goes to 0 and Y to iY_START (frame wrap).
REQ-010 Position arithmetic SHALL be 16-bit modulo 2^16, with no saturation.
REQ-011 oDAC_X and oDAC_Y SHALL change only on the edge that enters ST_LOAD and hold at all other times.
REQ-012 oDAC_LOAD SHALL be high only while in ST_LOAD; its first cycle SHALL begin 3 edges after the first edge that samples the trigger high.
REQ-013 ST_SETTLE SHALL last exactly iSETTLE_MILLISEC*CLK_CYCLES_PER_MS cycles (counter of at least 24 bits).
REQ-014 oGALVO_ACK SHALL be high only while in ST_ACK, beginning settle_cycles+1 edges after oDAC_LOAD rises.
REQ-015 A trigger edge outside ST_IDLE SHALL be dropped and SHALL set oOVERRUN.
REQ-016 iSCAN_RESET SHALL do the following from any state:
- Force ST_IDLE and clear the indices, re-arming first-trigger behaviour.
- Clear oOVERRUN and suppress any pending ACK or LOAD.
- Leave oDAC_X and oDAC_Y unchanged.
REQ-017 If iSCAN_RESET coincides with a trigger edge, iSCAN_RESET SHALL win and the edge SHALL be discarded.
REQ-018 A trigger held high SHALL produce only one edge; a new edge requires the trigger to go low first.

Reset
REQ-019 iRST SHALL force:
- state ST_IDLE;
- oDAC_X, oDAC_Y, oX_INDEX, oY_INDEX = 0;
- oDAC_LOAD, oGALVO_ACK, oBUSY, oOVERRUN = 0;
- synchronizer flops 0;
- first-trigger flag set.
REQ-020 iRST asserted mid-settle SHALL abort the settle with no ACK.

Configuration
REQ-021 Macro GALVO_SNAKE_SCAN_EN SHALL select the scan pattern.
- Defined: serpentine scan; at row end x_idx and X hold while the direction flips. Backward steps decrement x_idx and subtract iX_STEP. Frame wrap restores x_idx 0, X = iX_START, forward direction.
- Undefined: raster per REQ-009, and no direction register exists.

Verification
REQ-022 Reset, then trigger high for 50000 cycles with iX_START=100, settle=0 -> oDAC_X=100, LOAD at edge +3, ACK at edge +4, exactly one ACK.
REQ-023 iX_COUNT=3, iY_COUNT=2, iX_STEP=10, iY_STEP=5, starts 0, 7 triggers -> (X,Y) = (0,0) (10,0) (20,0) (0,5) (10,5) (20,5) (0,0).
REQ-024 Same setup with GALVO_SNAKE_SCAN_EN defined -> X sequence 0,10,20,20,10,0,0; Y sequence 0,0,0,5,5,5,0.
REQ-025 CLK_CYCLES_PER_MS=10, settle=3 -> ACK exactly 31 edges after LOAD; a second trigger during settle is dropped and sets oOVERRUN.
REQ-026 iSCAN_RESET asserted mid-settle -> no ACK, oBUSY=0 next cycle, next trigger loads iX_START and iY_START.
REQ-027 iX_START=16'hFFF0 with iX_STEP=16'h0020 -> next X = 16'h0010 (wraps).
